// File: rtl/axi4_slave_write_responder_if.sv
// AXI4 write-side channel bundle (AW, W, B) shared by the write responder and its driver.
// Clock and reset are kept outside the bundle as plain module ports.
interface axi4_slave_write_responder_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [3:0]               awid;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [7:0]               awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic                     awvalid;
  logic                     awready;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [DATA_WIDTH/8-1:0]  wstrb;
  logic                     wlast;
  logic                     wvalid;
  logic                     wready;
  logic [3:0]               bid;
  logic [1:0]               bresp;
  logic                     bvalid;
  logic                     bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi4_slave_write_responder.sv
// AXI4 write responder: in-order AW queue, FIXED/INCR/WRAP bursts into a byte-strobed
// local memory, one B response per burst, plus a registered debug readback port.
module axi4_slave_write_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int AW_FIFO_DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi4_slave_write_responder_if.slave  bus,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SZ_LOG = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int PTR_W  = $clog2(AW_FIFO_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct packed {
    logic [3:0]               id;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
  } aw_req_t;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  aw_req_t                  fifo [AW_FIFO_DEPTH];
  aw_req_t                  aw_in, head;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count, count_next;
  logic                     push, pop;
  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] addr, addr_next, step, wrap_total, wrap_base;
  logic [3:0]               cur_id;
  logic [7:0]               cur_len, beat_cnt;
  logic [2:0]               cur_size;
  logic [1:0]               cur_burst;
  logic [1:0]               err, err_next, load_err;
  logic                     beat, last_beat, in_range, wr_en;
  logic [IDX_W-1:0]         word_idx;
  logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];

  // ---------------- AW queue ----------------
  assign aw_in      = '{id: bus.awid, addr: bus.awaddr, len: bus.awlen,
                        size: bus.awsize, burst: bus.awburst};
  assign push       = bus.awvalid && bus.awready;
  assign head       = fifo[rd_ptr];
  assign count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.awready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      // Registered ready: only advertise space we are sure to still have next cycle.
      bus.awready <= (count_next != (PTR_W+1)'(AW_FIFO_DEPTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && push) fifo[wr_ptr] <= aw_in;
  end

  // ---------------- Burst control ----------------
  assign load_err = (head.burst == 2'b11 || head.size > 3'(SZ_LOG) ||
                     (head.burst == 2'b10 && !(head.len inside {8'd1, 8'd3, 8'd7, 8'd15})))
                    ? SLVERR : OKAY;

  assign last_beat  = (beat_cnt == cur_len);
  assign in_range   = (addr >> SZ_LOG) < ADDRESS_WIDTH'(MEM_DEPTH);
  assign word_idx   = addr[SZ_LOG +: IDX_W];
  assign step       = ADDRESS_WIDTH'(1) << cur_size;
  assign wrap_total = (ADDRESS_WIDTH'(cur_len) + 1'b1) << cur_size;
  assign wrap_base  = addr & ~(wrap_total - 1'b1);

  always_comb begin
    addr_next = addr;
    case (cur_burst)
      2'b01: addr_next = addr + step;
      2'b10: begin
        addr_next = addr + step;
        if (addr_next == wrap_base + wrap_total) addr_next = wrap_base;
      end
      default: addr_next = addr;
    endcase
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    beat       = 1'b0;
    wr_en      = 1'b0;
    err_next   = err;
    bus.wready = 1'b0;
    bus.bvalid = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop        = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        bus.wready = 1'b1;
        beat       = bus.wvalid;
        if (beat) begin
          if (!in_range && err == OKAY) err_next = DECERR;
          if (bus.wlast != last_beat)   err_next = SLVERR;
          // A beat carrying a misplaced wlast is itself treated as erroneous.
          wr_en = (err == OKAY) && in_range && (bus.wlast == last_beat);
          if (last_beat) state_next = RESP;
        end
      end
      RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      addr      <= '0;
      beat_cnt  <= '0;
      err       <= OKAY;
      cur_id    <= '0;
      cur_len   <= '0;
      cur_size  <= '0;
      cur_burst <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        addr      <= head.addr;
        beat_cnt  <= '0;
        err       <= load_err;
        cur_id    <= head.id;
        cur_len   <= head.len;
        cur_size  <= head.size;
        cur_burst <= head.burst;
      end else if (beat) begin
        err <= err_next;
        if (!last_beat) begin
          beat_cnt <= beat_cnt + 1'b1;
          addr     <= addr_next;
        end
      end
    end
  end

  assign bus.bid   = cur_id;
  assign bus.bresp = err;

  // ---------------- Memory ----------------
  always_ff @(posedge aclk) begin
    if (aresetn && wr_en) begin
      for (int i = 0; i < STRB_W; i++)
        if (bus.wstrb[i]) mem[word_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) dbg_rdata <= '0;
    else          dbg_rdata <= mem[dbg_addr];
  end
endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed bench for axi4_slave_write_responder: bursts, strobes, error responses,
// AW backpressure/ordering and reset in the middle of a burst.
module tb_axi4_slave_write_responder;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;
  int tests = 0;
  int fails = 0;

  axi4_slave_write_responder_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_slave_write_responder #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .AW_FIFO_DEPTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .bus(bus), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                    input logic [2:0] sz, input logic [1:0] bst);
    int n = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bst;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 50) begin step(); n++; end
    chk("aw_wait", 64'(n < 50), 64'd1);
    step();
    bus.awvalid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    bus.wdata = d; bus.wstrb = s; bus.wlast = l; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin step(); n++; end
    chk("w_wait", 64'(n < 50), 64'd1);
    step();
    bus.wvalid = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [3:0] id, input logic [1:0] r);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin step(); n++; end
    chk({tag, "_bvalid"}, 64'(bus.bvalid), 64'd1);
    chk({tag, "_bid"},    64'(bus.bid),    64'(id));
    chk({tag, "_bresp"},  64'(bus.bresp),  64'(r));
    step();
    bus.bready = 1'b0;
    chk({tag, "_bdone"},  64'(bus.bvalid), 64'd0);
  endtask

  task automatic chk_word(input string tag, input logic [9:0] a, input logic [31:0] e);
    dbg_addr = a;
    step();
    chk(tag, 64'(dbg_rdata), 64'(e));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"}, 64'(bus.awready), 64'd0);
    chk({tag, "_wready"},  64'(bus.wready),  64'd0);
    chk({tag, "_bvalid"},  64'(bus.bvalid),  64'd0);
    chk({tag, "_bid"},     64'(bus.bid),     64'd0);
    chk({tag, "_bresp"},   64'(bus.bresp),   64'd0);
    chk({tag, "_rdata"},   64'(dbg_rdata),   64'd0);
  endtask

  initial begin
    int n;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset values and first ready
    step(); step();
    chk_reset_outs("rst");
    aresetn = 1'b1;
    chk("rst_awready_hold", 64'(bus.awready), 64'd0);
    step();
    chk("rst_awready_up", 64'(bus.awready), 64'd1);

    // Known background contents
    aw(4'd1, 32'h0, 8'd1, 3'd2, 2'b01);
    beat(32'h600D600D, 4'hF, 1'b0);
    beat(32'h0000BEEF, 4'hF, 1'b1);
    resp("pre0", 4'd1, 2'b00);
    aw(4'd2, 32'h40, 8'd0, 3'd2, 2'b01);
    beat(32'h0, 4'hF, 1'b1);
    resp("pre16", 4'd2, 2'b00);
    aw(4'd3, 32'h50, 8'd7, 3'd2, 2'b01);
    for (int k = 0; k < 8; k++) beat(32'hCCCC0000 + 32'(k), 4'hF, k == 7);
    resp("pre20", 4'd3, 2'b00);

    // INCR with AW->W and W->B latency checks
    aw(4'd5, 32'h10, 8'd3, 3'd2, 2'b01);
    chk("incr_wready_early", 64'(bus.wready), 64'd0);
    step();
    chk("incr_wready_on", 64'(bus.wready), 64'd1);
    for (int k = 0; k < 4; k++) beat(32'hA0 + 32'(k), 4'hF, k == 3);
    chk("incr_bvalid_lat", 64'(bus.bvalid), 64'd1);
    resp("incr", 4'd5, 2'b00);
    for (int k = 0; k < 4; k++) chk_word("incr_word", 10'(4 + k), 32'hA0 + 32'(k));

    // WRAP: 0x38 -> 0x3C -> 0x30 -> 0x34
    aw(4'd6, 32'h38, 8'd3, 3'd2, 2'b10);
    for (int k = 0; k < 4; k++) beat(32'(k + 1), 4'hF, k == 3);
    resp("wrap", 4'd6, 2'b00);
    chk_word("wrap_w14", 10'd14, 32'd1);
    chk_word("wrap_w15", 10'd15, 32'd2);
    chk_word("wrap_w12", 10'd12, 32'd3);
    chk_word("wrap_w13", 10'd13, 32'd4);

    // FIXED with byte strobes
    aw(4'd2, 32'h40, 8'd1, 3'd2, 2'b00);
    beat(32'h00000011, 4'h1, 1'b0);
    beat(32'h00002200, 4'h2, 1'b1);
    resp("fixed", 4'd2, 2'b00);
    chk_word("fixed_w16", 10'd16, 32'h00002211);

    // Reserved burst type
    aw(4'd3, 32'h50, 8'd1, 3'd2, 2'b11);
    beat(32'hDEAD0000, 4'hF, 1'b0);
    beat(32'hDEAD0001, 4'hF, 1'b1);
    resp("rsvd", 4'd3, 2'b10);
    chk_word("rsvd_w20", 10'd20, 32'hCCCC0000);
    chk_word("rsvd_w21", 10'd21, 32'hCCCC0001);

    // Early wlast on beat 2 of 4
    aw(4'd7, 32'h58, 8'd3, 3'd2, 2'b01);
    beat(32'h11110001, 4'hF, 1'b0);
    beat(32'h11110002, 4'hF, 1'b1);
    beat(32'h11110003, 4'hF, 1'b0);
    beat(32'h11110004, 4'hF, 1'b0);
    resp("wlast", 4'd7, 2'b10);
    step();
    chk("wlast_single_resp", 64'(bus.bvalid), 64'd0);
    chk_word("wlast_w22", 10'd22, 32'h11110001);
    chk_word("wlast_w23", 10'd23, 32'hCCCC0003);
    chk_word("wlast_w24", 10'd24, 32'hCCCC0004);
    chk_word("wlast_w25", 10'd25, 32'hCCCC0005);

    // Oversized beat
    aw(4'd4, 32'h60, 8'd0, 3'd3, 2'b01);
    beat(32'h77777777, 4'hF, 1'b1);
    resp("size", 4'd4, 2'b10);
    chk_word("size_w24", 10'd24, 32'hCCCC0004);

    // Out-of-range address
    aw(4'd8, 32'h1000, 8'd0, 3'd2, 2'b01);
    beat(32'hFFFFFFFF, 4'hF, 1'b1);
    resp("decerr", 4'd8, 2'b11);
    chk_word("decerr_w0", 10'd0, 32'h600D600D);

    // Backpressure: five AWs fit (one popped + four queued), the sixth stalls
    for (int k = 1; k <= 5; k++) aw(4'(k), 32'h100 + 32'(4 * (k - 1)), 8'd0, 3'd2, 2'b01);
    chk("bp_full", 64'(bus.awready), 64'd0);
    bus.awid = 4'd6; bus.awaddr = 32'h114; bus.awlen = 8'd0; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    step(); step();
    chk("bp_aw6_blocked", 64'(bus.awready), 64'd0);
    beat(32'h101, 4'hF, 1'b1);
    resp("bp1", 4'd1, 2'b00);
    n = 0;
    while (!bus.awready && n < 20) begin step(); n++; end
    chk("bp_awready_rise", 64'(bus.awready), 64'd1);
    step();
    bus.awvalid = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      beat(32'h100 + 32'(k), 4'hF, 1'b1);
      resp("bp", 4'(k), 2'b00);
    end
    for (int k = 1; k <= 6; k++) chk_word("bp_word", 10'(63 + k), 32'h100 + 32'(k));

    // Reset asserted while beat 2 is presented
    aw(4'd9, 32'h0, 8'd3, 3'd2, 2'b01);
    beat(32'h12345678, 4'hF, 1'b0);
    bus.wdata = 32'h9ABCDEF0; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    aresetn = 1'b0;
    step();
    chk_reset_outs("mid");
    bus.wvalid = 1'b0;
    step();
    aresetn = 1'b1;
    step();
    chk("mid_awready_up", 64'(bus.awready), 64'd1);
    step(); step();
    chk("mid_no_wready", 64'(bus.wready), 64'd0);
    chk("mid_no_bvalid", 64'(bus.bvalid), 64'd0);
    chk_word("mid_w0", 10'd0, 32'h12345678);
    chk_word("mid_w1", 10'd1, 32'h0000BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
